lcd_access_arbiter: RTL and testbench

- Shares one HD44780-style character LCD between NUM_REQ KPN producer processes, each presenting a 16-bit token for display.
- Performs the power-on init sequence, then grants requesters round-robin and sequences the full write of one line per grant:
  - a DDRAM address command, then the character stream,
  - with enable-pulse and settle timing generated by internal counters.
- Sits between KPN output FIFOs and the LCD pins, replacing per-process LCD drivers.

---
 rtl/lcd_access_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_lcd_access_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lcd_access_arbiter
// Description : Shares one HD44780-style character LCD between NUM_REQ token
//               producers. Runs the power-on init sequence, then grants
//               requesters round-robin and writes one full display line per
//               grant: a DDRAM address command followed by the characters.
//               Optional macro LCD_HEX_EN: show each 16-bit token as 4 hex
//               characters instead of 16 binary characters.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_access_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int EN_CYCLES   = 2,
    parameter int WAIT_CYCLES = 4,
    parameter int CLEAR_WAIT  = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [16*NUM_REQ-1:0]   entry_data,
    output logic [NUM_REQ-1:0]      ack,
    output logic                    busy,
    output logic                    enable,
    output logic [7:0]              lcd_data,
    output logic                    rs,
    output logic                    rw,
    output logic                    on
);

    localparam int CW = 16;
`ifdef LCD_HEX_EN
    localparam int NCHAR = 4;
    localparam int CCW   = 2;
`else
    localparam int NCHAR = 16;
    localparam int CCW   = 4;
`endif

    typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_ADDR, ST_CHAR, ST_DONE} state_t;
    typedef enum logic [1:0] {PH_NONE, PH_SETUP, PH_PULSE, PH_HOLD} phase_t;

    state_t             state_q;
    phase_t             ph_q;
    logic [CW-1:0]      cnt_q;
    logic [1:0]         init_idx_q;
    logic [CCW-1:0]     char_cnt_q;
    logic [15:0]        tok_q;
    logic [1:0]         ptr_q;
    logic [7:0]         lcd_data_q;
    logic               rs_q;
    logic               en_q;
    logic               on_q;
    logic               busy_q;
    logic [NUM_REQ-1:0] ack_q;

    logic [3:0]         req_pad;
    logic [63:0]        data_pad;
    logic [1:0]         rr_idx;
    logic               gnt_vld_d;
    logic [1:0]         gnt_d;
    logic [15:0]        gnt_tok_d;
    logic               wr_done;
    logic               is_clear;

    assign req_pad  = 4'(req);
    assign data_pad = 64'(entry_data);
    assign wr_done  = (ph_q == PH_HOLD) && (cnt_q == '0);
    assign is_clear = (state_q == ST_INIT) && (init_idx_q == 2'd3);

    assign ack      = ack_q;
    assign busy     = busy_q;
    assign enable   = en_q;
    assign lcd_data = lcd_data_q;
    assign rs       = rs_q;
    assign rw       = 1'b0;
    assign on       = on_q;

    // Power-on command list; the last entry is the slow clear-display.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h06;
            default: init_cmd = 8'h01;
        endcase
    endfunction

    // Character for position c of the token (c counts down to 0, so the
    // highest position is the most significant digit).
    function automatic logic [7:0] char_of(input logic [15:0] tok, input logic [CCW-1:0] c);
        logic [15:0] sh;
`ifdef LCD_HEX_EN
        logic [3:0]  nib;
        sh  = tok >> {c, 2'b00};
        nib = sh[3:0];
        char_of = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
`else
        sh  = tok >> c;
        char_of = {7'b0011000, sh[0]};
`endif
    endfunction

    // Round-robin search starting just after the last granted requester;
    // scanning from the far end lets the nearest pending requester win.
    always_comb begin
        gnt_vld_d = 1'b0;
        gnt_d     = ptr_q;
        rr_idx    = ptr_q;
        for (int k = NUM_REQ; k >= 1; k--) begin
            rr_idx = 2'((int'(ptr_q) + k) % NUM_REQ);
            if (req_pad[rr_idx]) begin
                gnt_vld_d = 1'b1;
                gnt_d     = rr_idx;
            end
        end
        gnt_tok_d = 16'(data_pad >> {gnt_d, 4'b0000});
    end

    // Controller FSM plus write engine; a new write is launched by loading
    // lcd_data/rs and entering SETUP on the edge that ends the previous one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_INIT;
            ph_q       <= PH_NONE;
            cnt_q      <= '0;
            init_idx_q <= 2'd0;
            char_cnt_q <= '0;
            tok_q      <= 16'h0000;
            ptr_q      <= 2'(NUM_REQ - 1);
            lcd_data_q <= 8'h00;
            rs_q       <= 1'b0;
            en_q       <= 1'b0;
            on_q       <= 1'b0;
            busy_q     <= 1'b1;
            ack_q      <= '0;
        end else begin
            on_q  <= 1'b1;
            ack_q <= '0;

            case (ph_q)
                PH_SETUP: begin
                    en_q  <= 1'b1;
                    ph_q  <= PH_PULSE;
                    cnt_q <= CW'(EN_CYCLES - 1);
                end
                PH_PULSE: begin
                    if (cnt_q == '0) begin
                        en_q  <= 1'b0;
                        ph_q  <= PH_HOLD;
                        cnt_q <= is_clear ? CW'(CLEAR_WAIT - 1) : CW'(WAIT_CYCLES - 1);
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                PH_HOLD: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
                end
                default: ;
            endcase

            case (state_q)
                ST_INIT: begin
                    if (ph_q == PH_NONE) begin
                        lcd_data_q <= init_cmd(init_idx_q);
                        rs_q       <= 1'b0;
                        ph_q       <= PH_SETUP;
                    end else if (wr_done) begin
                        if (init_idx_q == 2'd3) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            ph_q    <= PH_NONE;
                        end else begin
                            init_idx_q <= init_idx_q + 2'd1;
                            lcd_data_q <= init_cmd(init_idx_q + 2'd1);
                            ph_q       <= PH_SETUP;
                        end
                    end
                end
                ST_IDLE: begin
                    if (gnt_vld_d) begin
                        tok_q      <= gnt_tok_d;
                        ptr_q      <= gnt_d;
                        state_q    <= ST_ADDR;
                        busy_q     <= 1'b1;
                        lcd_data_q <= {1'b1, gnt_d[0], 6'b000000};
                        rs_q       <= 1'b0;
                        ph_q       <= PH_SETUP;
                    end
                end
                ST_ADDR: begin
                    if (wr_done) begin
                        state_q    <= ST_CHAR;
                        char_cnt_q <= CCW'(NCHAR - 1);
                        lcd_data_q <= char_of(tok_q, CCW'(NCHAR - 1));
                        rs_q       <= 1'b1;
                        ph_q       <= PH_SETUP;
                    end
                end
                ST_CHAR: begin
                    if (wr_done) begin
                        if (char_cnt_q == '0) begin
                            state_q <= ST_DONE;
                            ack_q   <= NUM_REQ'(1) << ptr_q;
                            ph_q    <= PH_NONE;
                        end else begin
                            char_cnt_q <= char_cnt_q - CCW'(1);
                            lcd_data_q <= char_of(tok_q, char_cnt_q - CCW'(1));
                            ph_q       <= PH_SETUP;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_access_arbiter
// Description : Scoreboard bench for lcd_access_arbiter. Stimulus pushes the
//               expected LCD writes and acks; a monitor pops and compares on
//               every enable pulse and every ack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_access_arbiter;

    localparam int NUM_REQ = 2;
    localparam int EN      = 2;
    localparam int WT      = 4;
    localparam int CLRW    = 8;
`ifdef LCD_HEX_EN
    localparam int NCHAR = 4;
`else
    localparam int NCHAR = 16;
`endif
    // Edges from the address-command enable rise to the ack sample.
    localparam int LAT = (1 + NCHAR) * (1 + EN + WT) - 1;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } wr_t;

    logic                  clock = 1'b0;
    logic                  reset_n;
    logic [NUM_REQ-1:0]    req;
    logic [16*NUM_REQ-1:0] entry_data;
    logic [NUM_REQ-1:0]    ack;
    logic                  busy, enable, rs, rw, on;
    logic [7:0]            lcd_data;

    wr_t                exp_wr[$];
    logic [NUM_REQ-1:0] exp_ack[$];
    logic [15:0]        work[NUM_REQ][$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int addr_cyc = 0;
    int nchar_seen = 0;
    int model_ptr;

    lcd_access_arbiter #(
        .NUM_REQ(NUM_REQ), .EN_CYCLES(EN), .WAIT_CYCLES(WT), .CLEAR_WAIT(CLRW)
    ) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .entry_data(entry_data),
        .ack(ack), .busy(busy), .enable(enable), .lcd_data(lcd_data),
        .rs(rs), .rw(rw), .on(on)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference character: k-th character from the left of the display line.
    function automatic logic [7:0] exp_char(input logic [15:0] tok, input int k);
`ifdef LCD_HEX_EN
        int nib;
        nib = (int'(tok) >> (12 - 4 * k)) & 15;
        exp_char = (nib < 10) ? 8'(48 + nib) : 8'(65 + nib - 10);
`else
        exp_char = (((int'(tok) >> (15 - k)) & 1) != 0) ? "1" : "0";
`endif
    endfunction

    task automatic push_init();
        exp_wr.push_back({1'b0, 8'h38});
        exp_wr.push_back({1'b0, 8'h0C});
        exp_wr.push_back({1'b0, 8'h06});
        exp_wr.push_back({1'b0, 8'h01});
    endtask

    task automatic push_txn(input int i, input logic [15:0] tok);
        logic [NUM_REQ-1:0] a;
        exp_wr.push_back({1'b0, ((i % 2) == 1) ? 8'hC0 : 8'h80});
        for (int k = 0; k < NCHAR; k++) exp_wr.push_back({1'b1, exp_char(tok, k)});
        a = '0;
        a[i] = 1'b1;
        exp_ack.push_back(a);
    endtask

    // Monitor: every enable rise pops one expected write, every ack pops one
    // expected ack; pulse width and bus stability are checked along the way.
    initial begin
        logic       prev_en, in_pulse;
        logic [7:0] cap_d;
        logic       cap_rs;
        int         width;
        wr_t        w;
        prev_en = 1'b0; in_pulse = 1'b0; width = 0; cap_d = 8'h00; cap_rs = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                prev_en = 1'b0; in_pulse = 1'b0;
                continue;
            end
            if (enable && !prev_en) begin
                cap_d = lcd_data; cap_rs = rs; width = 1; in_pulse = 1'b1;
                check("rw_low", 32'(rw), 32'd0);
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", 32'({rs, lcd_data}), 32'h1FF);
                end else begin
                    w = exp_wr.pop_front();
                    check("write_rs_data", 32'({rs, lcd_data}), 32'(w));
                end
                if (!rs && lcd_data[7]) addr_cyc = cyc;
                if (rs) nchar_seen++;
            end else if (enable && in_pulse) begin
                width++;
                check("bus_stable", 32'({rs, lcd_data}), 32'({cap_rs, cap_d}));
            end else if (!enable && prev_en && in_pulse) begin
                check("pulse_width", 32'(width), 32'(EN));
                in_pulse = 1'b0;
            end
            if (ack != '0) begin
                if (exp_ack.size() == 0) begin
                    check("unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    check("ack_onehot", 32'(ack), 32'(exp_ack.pop_front()));
                    check("ack_latency", 32'(cyc - addr_cyc), 32'(LAT));
                end
            end
            prev_en = enable;
        end
    end

    // Drives all requesters from their work queues; a requester re-raises
    // immediately after its ack while it still has tokens.
    task automatic run_batch();
        logic [15:0] mw[NUM_REQ][$];
        int total, budget, j;
        logic any;
        total = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            mw[i] = work[i];
            total += work[i].size();
        end
        // Model: every requester with tokens left is pending at each decision.
        any = 1'b1;
        while (any) begin
            any = 1'b0;
            for (int k = 1; k <= NUM_REQ; k++) begin
                j = (model_ptr + k) % NUM_REQ;
                if (mw[j].size() != 0) begin
                    push_txn(j, mw[j].pop_front());
                    model_ptr = j;
                    any = 1'b1;
                    break;
                end
            end
        end
        budget = 200 * total + 100;
        forever begin
            any = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ack[i] && work[i].size() != 0) void'(work[i].pop_front());
                if (work[i].size() != 0) begin
                    req[i] = 1'b1;
                    entry_data[16*i +: 16] = work[i][0];
                    any = 1'b1;
                end else begin
                    req[i] = 1'b0;
                end
            end
            if (!any) break;
            if (budget == 0) begin
                check("batch_timeout", 32'd1, 32'd0);
                for (int i = 0; i < NUM_REQ; i++) work[i].delete();
                req = '0;
                break;
            end
            budget--;
            @(negedge clock);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic wait_ack(input int i);
        int n;
        n = 0;
        while (!ack[i] && n < 500) begin
            @(negedge clock);
            n++;
        end
        check("ack_arrived", 32'(ack[i]), 32'd1);
    endtask

    task automatic check_reset_vals();
        check("rst_enable", 32'(enable), 32'd0);
        check("rst_lcd_data", 32'(lcd_data), 32'd0);
        check("rst_rs", 32'(rs), 32'd0);
        check("rst_rw", 32'(rw), 32'd0);
        check("rst_on", 32'(on), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [15:0] tok;
        reset_n = 1'b0;
        req = '0;
        entry_data = '0;
        model_ptr = NUM_REQ - 1;

        // Reset values and init sequence with no requests.
        #7;
        check_reset_vals();
        push_init();
        #5 reset_n = 1'b1;
        n = 0;
        @(negedge clock);
        n++;
        check("on_after_first_edge", 32'(on), 32'd1);
        while (busy && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("init_cycles", 32'(n), 32'd33);

        // Both held: tokens 0001 and 8000, two grants each, alternating.
        work[0].push_back(16'h0001); work[0].push_back(16'h0001);
        work[1].push_back(16'h8000); work[1].push_back(16'h8000);
        run_batch();

        // Single requester 0 with A5F0.
        wait_idle();
        work[0].push_back(16'hA5F0);
        run_batch();

        // One-cycle pulse on req[1]; data changes right after the grant.
        wait_idle();
        tok = 16'($urandom);
        req[1] = 1'b1;
        entry_data[31:16] = tok;
        push_txn(1, tok);
        model_ptr = 1;
        @(negedge clock);
        req[1] = 1'b0;
        entry_data[31:16] = ~tok;
        wait_ack(1);

        // Randomized round-robin batches.
        for (int r = 0; r < 4; r++) begin
            wait_idle();
            for (int i = 0; i < NUM_REQ; i++) begin
                n = int'($urandom_range(0, 3));
                for (int k = 0; k < n; k++) work[i].push_back(16'($urandom));
            end
            run_batch();
        end

        // Reset during the 8th character write of requester 0.
        wait_idle();
        tok = 16'($urandom);
        req[0] = 1'b1;
        entry_data[15:0] = tok;
        push_txn(0, tok);
        n = nchar_seen;
        for (int c = 0; c < 400 && nchar_seen < n + 8; c++) begin
            @(negedge clock);
            #1;
        end
        check("eighth_char_seen", 32'(nchar_seen - n), 32'd8);
        reset_n = 1'b0;
        #1;
        check_reset_vals();
        exp_wr.delete();
        exp_ack.delete();
        push_init();
        model_ptr = 0;
        push_txn(0, tok);
        repeat (3) @(negedge clock);
        check_reset_vals();
        #2 reset_n = 1'b1;
        wait_ack(0);
        req[0] = 1'b0;
        repeat (4) @(negedge clock);

        check("writes_left", 32'(exp_wr.size()), 32'd0);
        check("acks_left", 32'(exp_ack.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
